// File: rtl/param_up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the parametrised up/down counter family.
//   cnt_mode_e : boundary behaviour (CNT_WRAP = modulo wrap, CNT_SAT = clamp)
//   clamp_max  : limits a value to a ceiling; used to clamp load values
// -----------------------------------------------------------------------------
package cnt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Operates on a fixed 32-bit width so any counter width up to 32 can
    // zero-extend into it and truncate back out.
    function automatic logic [31:0] clamp_max(input logic [31:0] value,
                                              input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/param_up_down_counter_if.sv
// -----------------------------------------------------------------------------
// param_up_down_counter_if
// Control/status bundle of the parametrised up/down counter.
//   enable, up_down, preset, load, load_val, step, clr_flags : control inputs
//   counter, tc, ovf, unf                                   : registered status
// Modports:
//   master : drives control, observes status (the counter's user)
//   slave  : the counter itself
// -----------------------------------------------------------------------------
interface param_up_down_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic             up_down;
    logic             preset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step;
    logic             clr_flags;
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             ovf;
    logic             unf;

    modport master (
        output enable, up_down, preset, load, load_val, step, clr_flags,
        input  counter, tc, ovf, unf
    );

    modport slave (
        input  enable, up_down, preset, load, load_val, step, clr_flags,
        output counter, tc, ovf, unf
    );
endinterface

// File: rtl/param_up_down_counter_cnt_next_calc.sv
// -----------------------------------------------------------------------------
// cnt_next_calc
// Purely combinational next-count calculation for one enabled count step.
//   counter_i    : current count (always <= MAX_VAL)
//   step_i       : increment/decrement amount
//   up_down_i    : 1 = up, 0 = down
//   next_count_o : count after the step (wrapped or saturated)
//   ovf_evt_o    : step crossed above MAX_VAL (including a push at the rail)
//   unf_evt_o    : step crossed below 0 (including a push at the rail)
// -----------------------------------------------------------------------------
module cnt_next_calc
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0] counter_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             up_down_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             ovf_evt_o,
    output logic             unf_evt_o
);

    localparam cnt_mode_e      MODE  = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MOD_X = MAX_X + (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] raw_x;

    always_comb begin
        cnt_x     = {1'b0, counter_i};
        step_x    = {1'b0, step_i};
        sum_x     = cnt_x + step_x;
        raw_x     = cnt_x;
        ovf_evt_o = 1'b0;
        unf_evt_o = 1'b0;

        if (up_down_i) begin
            if (sum_x <= MAX_X) begin
                raw_x = sum_x;
            end else begin
                ovf_evt_o = 1'b1;
                raw_x     = (MODE == CNT_SAT) ? MAX_X : (sum_x - MOD_X);
            end
        end else begin
            if (step_x <= cnt_x) begin
                raw_x = cnt_x - step_x;
            end else begin
                unf_evt_o = 1'b1;
                raw_x     = (MODE == CNT_SAT) ? '0 : (cnt_x + MOD_X - step_x);
            end
        end

        // An out-of-range step can leave the wrapped value above the rail;
        // pin it so the count register never leaves 0..MAX_VAL.
        if (raw_x > MAX_X) begin
            raw_x = MAX_X;
        end

        next_count_o = raw_x[WIDTH-1:0];
    end

endmodule

// File: rtl/param_up_down_counter.sv
// -----------------------------------------------------------------------------
// param_up_down_counter
// Parametrised up/down event counter with programmable step, synchronous
// preset/load, wrap or saturate at the boundaries, a one-cycle terminal-count
// pulse and sticky overflow/underflow flags.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : control/status bundle (slave side), see param_up_down_counter_if
// Edge priority: reset > preset > load > enabled count > hold.
// -----------------------------------------------------------------------------
module param_up_down_counter
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    param_up_down_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    logic [WIDTH-1:0] calc_next;
    logic [WIDTH-1:0] load_clamped;
    logic             ovf_evt;
    logic             unf_evt;
    logic             count_en;

    cnt_next_calc #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next_calc (
        .counter_i    (counter_q),
        .step_i       (bus.step),
        .up_down_i    (bus.up_down),
        .next_count_o (calc_next),
        .ovf_evt_o    (ovf_evt),
        .unf_evt_o    (unf_evt)
    );

    always_comb begin
        load_clamped = WIDTH'(clamp_max(32'(bus.load_val), 32'(MAX_VAL)));
        count_en     = !bus.preset && !bus.load && bus.enable;

        counter_d = counter_q;
        tc_d      = 1'b0;

        if (bus.preset) begin
            counter_d = MAX_W;
        end else if (bus.load) begin
            counter_d = load_clamped;
        end else if (bus.enable) begin
            counter_d = calc_next;
            tc_d      = ovf_evt | unf_evt;
        end

        // A fresh event on the clearing edge re-sets its flag.
        ovf_d = (ovf_q & ~bus.clr_flags) | (count_en & ovf_evt);
        unf_d = (unf_q & ~bus.clr_flags) | (count_en & unf_evt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q <= '0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign bus.counter = counter_q;
    assign bus.tc      = tc_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_param_up_down_counter
// Three counters side by side: decade wrap (u0), decade saturate (u1) and
// 8-bit wrap (u2). u0/u1 share one stimulus stream, u2 has its own. A
// behavioural model tracks every counter; directed scenarios add fixed
// expected values, then a randomized phase runs against the model alone.
// -----------------------------------------------------------------------------
module tb_param_up_down_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    param_up_down_counter_if #(.WIDTH(4)) u0 ();
    param_up_down_counter_if #(.WIDTH(4)) u1 ();
    param_up_down_counter_if #(.WIDTH(8)) u2 ();

    param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0))
        dut0 (.clk(clk), .reset(rst_n), .bus(u0));
    param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1))
        dut1 (.clk(clk), .reset(rst_n), .bus(u1));
    param_up_down_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0))
        dut2 (.clk(clk), .reset(rst_n), .bus(u2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // stimulus for u0/u1 (s_*) and u2 (w_*)
    bit s_en, s_ud, s_pre, s_ld, s_clr;
    int s_lv, s_st;
    bit w_en, w_ud, w_pre, w_ld, w_clr;
    int w_lv, w_st;

    // reference model state
    int m_cnt [3];
    bit m_tc  [3];
    bit m_ovf [3];
    bit m_unf [3];
    int m_max [3] = '{9, 9, 255};
    bit m_sat [3] = '{1'b0, 1'b1, 1'b0};

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input int i, input bit en, input bit ud,
                                       input bit pre, input bit ld, input int lv,
                                       input int st, input bit clr);
        bit eo = 1'b0;
        bit eu = 1'b0;
        int mx = m_max[i];
        if (pre) begin
            m_cnt[i] = mx;
        end else if (ld) begin
            m_cnt[i] = (lv > mx) ? mx : lv;
        end else if (en && st > 0) begin
            if (ud) begin
                if (m_cnt[i] + st > mx) begin
                    eo = 1'b1;
                    m_cnt[i] = m_sat[i] ? mx : m_cnt[i] + st - (mx + 1);
                end else begin
                    m_cnt[i] = m_cnt[i] + st;
                end
            end else begin
                if (st > m_cnt[i]) begin
                    eu = 1'b1;
                    m_cnt[i] = m_sat[i] ? 0 : m_cnt[i] + (mx + 1) - st;
                end else begin
                    m_cnt[i] = m_cnt[i] - st;
                end
            end
        end
        m_tc[i]  = eo || eu;
        m_ovf[i] = (m_ovf[i] && !clr) || eo;
        m_unf[i] = (m_unf[i] && !clr) || eu;
    endfunction

    task automatic compare_all();
        check("cnt0", int'(u0.counter), m_cnt[0]);
        check("tc0",  int'(u0.tc),      int'(m_tc[0]));
        check("ovf0", int'(u0.ovf),     int'(m_ovf[0]));
        check("unf0", int'(u0.unf),     int'(m_unf[0]));
        check("cnt1", int'(u1.counter), m_cnt[1]);
        check("tc1",  int'(u1.tc),      int'(m_tc[1]));
        check("ovf1", int'(u1.ovf),     int'(m_ovf[1]));
        check("unf1", int'(u1.unf),     int'(m_unf[1]));
        check("cnt2", int'(u2.counter), m_cnt[2]);
        check("tc2",  int'(u2.tc),      int'(m_tc[2]));
        check("ovf2", int'(u2.ovf),     int'(m_ovf[2]));
        check("unf2", int'(u2.unf),     int'(m_unf[2]));
    endtask

    task automatic drive();
        u0.enable = s_en;  u0.up_down = s_ud;  u0.preset = s_pre;  u0.load = s_ld;
        u0.load_val = 4'(s_lv);  u0.step = 4'(s_st);  u0.clr_flags = s_clr;
        u1.enable = s_en;  u1.up_down = s_ud;  u1.preset = s_pre;  u1.load = s_ld;
        u1.load_val = 4'(s_lv);  u1.step = 4'(s_st);  u1.clr_flags = s_clr;
        u2.enable = w_en;  u2.up_down = w_ud;  u2.preset = w_pre;  u2.load = w_ld;
        u2.load_val = 8'(w_lv);  u2.step = 8'(w_st);  u2.clr_flags = w_clr;
    endtask

    task automatic idle_all();
        s_en = 0; s_ud = 0; s_pre = 0; s_ld = 0; s_clr = 0; s_lv = 0; s_st = 0;
        w_en = 0; w_ud = 0; w_pre = 0; w_ld = 0; w_clr = 0; w_lv = 0; w_st = 0;
    endtask

    // Entered and left at a falling edge.
    task automatic tick();
        drive();
        assert (s_st <= 9 && w_st <= 255) else $error("illegal step in stimulus");
        @(posedge clk);
        if (rst_n) begin
            model_edge(0, s_en, s_ud, s_pre, s_ld, s_lv, s_st, s_clr);
            model_edge(1, s_en, s_ud, s_pre, s_ld, s_lv, s_st, s_clr);
            model_edge(2, w_en, w_ud, w_pre, w_ld, w_lv, w_st, w_clr);
        end
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Mid-cycle asynchronous reset pulse spanning one rising edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_d3 [5] = '{9, 6, 3, 0, 7};
    int exp_t3 [5] = '{1, 0, 0, 0, 1};
    int tc_pulses;

    initial begin
        rst_n = 1'b0;
        idle_all();
        drive();
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: asynchronous reset mid-count at 6, then count from 0
        s_ld = 1; s_lv = 5; tick();
        s_ld = 0; s_en = 1; s_ud = 1; s_st = 1; tick();
        check("t1_six", int'(u0.counter), 6);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t1_async_cnt", int'(u0.counter), 0);
        compare_all();
        @(posedge clk);
        #1;
        check("t1_held_low", int'(u0.counter), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check("t1_first", int'(u0.counter), 1);
        tick(); check("t1_second", int'(u0.counter), 2);

        // 2: wrap up by 1 through 9 -> 0, then clear the flag
        s_en = 0; s_ld = 1; s_lv = 0; tick();
        s_ld = 0; s_en = 1; s_ud = 1; s_st = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t2_cnt", int'(u0.counter), (i + 1) % 10);
            check("t2_tc",  int'(u0.tc), (i == 9) ? 1 : 0);
            check("t2_ovf", int'(u0.ovf), (i >= 9) ? 1 : 0);
        end
        s_en = 0; s_clr = 1; tick();
        check("t2_clr", int'(u0.ovf), 0);
        s_clr = 0;

        // 3: wrap down by 3 from 2
        s_ld = 1; s_lv = 2; tick();
        s_ld = 0; s_en = 1; s_ud = 0; s_st = 3;
        tc_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_cnt", int'(u0.counter), exp_d3[i]);
            check("t3_tc",  int'(u0.tc), exp_t3[i]);
            check("t3_unf", int'(u0.unf), 1);
            tc_pulses += int'(u0.tc);
        end
        check("t3_pulses", tc_pulses, 2);

        // 4: saturate instance, up by 4 from 7 then down
        s_en = 0; s_clr = 1; s_ld = 1; s_lv = 7; tick();
        s_clr = 0; s_ld = 0; s_en = 1; s_ud = 1; s_st = 4;
        tick();
        check("t4_sat_up", int'(u1.counter), 9);
        check("t4_ovf", int'(u1.ovf), 1);
        check("t4_tc1", int'(u1.tc), 1);
        tick();
        check("t4_rail", int'(u1.counter), 9);
        check("t4_tc2", int'(u1.tc), 1);
        s_ud = 0;
        tick(); check("t4_d5", int'(u1.counter), 5);
        tick(); check("t4_d1", int'(u1.counter), 1);
        tick();
        check("t4_d0", int'(u1.counter), 0);
        check("t4_unf", int'(u1.unf), 1);
        check("t4_tc3", int'(u1.tc), 1);

        // 5: preset beats load; load clamps
        s_pre = 1; s_ld = 1; s_lv = 3; s_en = 1; s_ud = 1; s_st = 1; tick();
        check("t5_pre", int'(u0.counter), 9);
        check("t5_pre_tc", int'(u0.tc), 0);
        s_pre = 0; s_lv = 15; tick();
        check("t5_clamp", int'(u0.counter), 9);
        check("t5_clamp_tc", int'(u0.tc), 0);
        s_lv = 4; tick();
        check("t5_load4", int'(u0.counter), 4);
        check("t5_load_tc", int'(u0.tc), 0);

        // 6: 8-bit wrap with set-wins-over-clear
        idle_all();
        w_ld = 1; w_lv = 100; tick();
        w_ld = 0; w_en = 1; w_ud = 1; w_st = 200; tick();
        check("t6_44", int'(u2.counter), 44);
        check("t6_ovf", int'(u2.ovf), 1);
        w_clr = 1; w_st = 250; tick();
        check("t6_38", int'(u2.counter), 38);
        check("t6_setwins", int'(u2.ovf), 1);
        idle_all();

        // randomized phase
        for (int n = 0; n < 600; n++) begin
            s_en  = ($urandom_range(0, 3) != 0);
            s_ud  = $urandom_range(0, 1) != 0;
            s_pre = ($urandom_range(0, 15) == 0);
            s_ld  = ($urandom_range(0, 7) == 0);
            s_clr = ($urandom_range(0, 7) == 0);
            s_lv  = int'($urandom_range(0, 15));
            s_st  = int'($urandom_range(0, 9));
            w_en  = ($urandom_range(0, 3) != 0);
            w_ud  = $urandom_range(0, 1) != 0;
            w_pre = ($urandom_range(0, 15) == 0);
            w_ld  = ($urandom_range(0, 7) == 0);
            w_clr = ($urandom_range(0, 7) == 0);
            w_lv  = int'($urandom_range(0, 255));
            w_st  = int'($urandom_range(0, 255));
            tick();
            if (n == 300) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_up_down_counter.md
Name: param_up_down_counter

Overview:
Parametrised successor to the 4-bit up/down counter. Adds configurable width and modulus, a programmable step, an enable, a synchronous load, and a selectable wrap or saturate mode. It also adds a terminal-count pulse and sticky overflow/underflow flags. It is used as a general event/timer counter (decade, modulo-N, BCD digit) feeding datapath and control blocks.

Parameters:
WIDTH, 4, counter width in bits (>=2).
MAX_VAL, 2**WIDTH-1, highest legal count (modulus-1); must be <= 2**WIDTH-1.
SATURATE, 0, 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  count enable; counter holds when 0.
up_down  input  1  direction: 1 = count up, 0 = count down.
preset  input  1  synchronous preset; loads MAX_VAL.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  value to load; values > MAX_VAL are clamped to MAX_VAL.
step  input  WIDTH  increment/decrement amount; legal range 0..MAX_VAL.
clr_flags  input  1  synchronous clear of ovf/unf.
counter  output  WIDTH  current count, registered.
tc  output  1  one-cycle registered pulse on a boundary event.
ovf  output  1  sticky overflow flag.
unf  output  1  sticky underflow flag.

Behaviour:
- reset low (asynchronous): counter=0, tc=0, ovf=0, unf=0 immediately. Release is synchronous to the next clk edge; no count on the release edge if reset is still low at that edge.
- Priority per rising edge: preset > load > (enable count) > hold.
- preset=1: counter<=MAX_VAL; tc<=0; flags unchanged.
- load=1 (preset=0): counter<=min(load_val, MAX_VAL); tc<=0; flags unchanged.
- enable=1, up_down=1: compute sum = counter+step in WIDTH+1 bits.
  - If sum <= MAX_VAL: counter<=sum.
  - Else, wrap mode: counter<=sum-(MAX_VAL+1). Saturate mode: counter<=MAX_VAL.
  - Either way, the overflow event sets tc<=1 and ovf<=1.
- enable=1, up_down=0:
  - If step <= counter: counter<=counter-step.
  - Else, wrap mode: counter<=counter+(MAX_VAL+1)-step. Saturate mode: counter<=0.
  - Either way, the underflow event sets tc<=1 and unf<=1.
- Saturate mode: a further count against the rail (counter already at the rail, step>0) is still an event. tc pulses every such cycle; ovf/unf stay set.
- step=0: counter holds, no event, tc<=0.
- enable=0 with no preset/load: counter holds, tc<=0.
- Latency: one clock from input to counter/tc/ovf/unf. All outputs come from flops; none are combinational.
- tc is high for exactly the cycle after the event edge and low otherwise.
- clr_flags=1 clears ovf and unf on the same edge. If an event occurs on that edge, the new event's flag wins and is set.
- Counter never holds a value > MAX_VAL under any input sequence.
- Direction change mid-count takes effect on the next edge with no bubble.
- step > MAX_VAL is illegal. The bench asserts on it; RTL behaviour is don't-care but must still keep counter <= MAX_VAL.
- Reset assertion mid-operation overrides everything, including a pending preset or load.

Decomposition:
- Shared package cnt_pkg: mode constants CNT_WRAP=0 and CNT_SAT=1, plus a function clamp_max(value, max) reused for load_val.
- One sub-module is natural: cnt_next_calc. It is purely combinational and takes counter, step, up_down, MAX_VAL and SATURATE. It returns next_count, ovf_evt and unf_evt.
- The top-level holds the registers, priority mux and flag logic.

Test Plan:
Use WIDTH=4, MAX_VAL=9 (decade counter) unless stated.
1. Reset low mid-count at counter=6 -> counter=0, tc=0, ovf=0, unf=0 immediately, without waiting for a clk edge. Release reset, enable=1, up, step=1 -> 0,1,2... from the second edge.
2. Wrap mode, up, step=1 from 0 for 12 edges -> 1..9,0,1,2. tc high only in the cycle after 9->0. ovf=1 thereafter. clr_flags pulse -> ovf=0.
3. Wrap mode, down, step=3 from counter=2 -> 9 (2+10-3), then 6, 3, 0, 7. unf set on both wraps. tc pulses twice.
4. SATURATE=1, up, step=4 from 7 -> 9 with ovf=1 and tc pulse. Next edge stays at 9 with tc pulsing again. Switch to down -> 5, 1, 0 (saturate), unf=1.
5. Same edge preset=1, load=1, load_val=3, enable=1 -> counter=9. Then load=1 with load_val=15 -> counter=9 (clamped). Then load_val=4 -> 4. tc=0 on all load/preset edges.
6. WIDTH=8, MAX_VAL=255, wrap, up, step=200 from 100 -> 44 with ovf=1. Then clr_flags=1 on an edge where 44+250 overflows -> 38, ovf stays 1 (set wins).
